// File: rtl/counter_4bit_if.sv
// counter_4bit_if: control/status bundle for counter_4bit.
//   en, up_dn, load, load_val : driven by the controlling block (master)
//   out, tc                   : driven by the counter (slave)
//   ovf                       : sticky overflow, present only when
//                               COUNTER_OVERFLOW_STICKY_EN is defined
interface counter_4bit_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
`ifdef COUNTER_OVERFLOW_STICKY_EN
  logic             ovf;

  modport master (
    output en, up_dn, load, load_val,
    input  out, tc, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output out, tc, ovf
  );
`else
  modport master (
    output en, up_dn, load, load_val,
    input  out, tc
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output out, tc
  );
`endif
endinterface

// File: rtl/counter_4bit.sv
// counter_4bit: synchronous up/down counter with enable, parallel load and a
// one-cycle terminal-count pulse on wrap.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - counter_4bit_if.slave (en, up_dn, load, load_val -> out, tc[, ovf])
// Parameters:
//   WIDTH     - counter width, 2..32
//   RESET_VAL - reset value, truncated to WIDTH bits
// Optional feature macro: COUNTER_OVERFLOW_STICKY_EN adds the sticky ovf flag,
// set on any wrap and cleared by rst or load.
// Priority each edge: rst > load > en > hold.
module counter_4bit #(
  parameter int          WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  counter_4bit_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic             tc_q;
  logic             wrap;

  // A wrap happens when counting up from all-ones or down from zero.
  assign wrap = bus.en & (bus.up_dn ? (&cnt) : ~(|cnt));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= RST_V;
      tc_q <= 1'b0;
    end else if (bus.load) begin
      cnt  <= bus.load_val;
      tc_q <= 1'b0;
    end else if (bus.en) begin
      cnt  <= bus.up_dn ? (cnt + ONE) : (cnt - ONE);
      tc_q <= wrap;
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign bus.out = cnt;
  assign bus.tc  = tc_q;

`ifdef COUNTER_OVERFLOW_STICKY_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst || bus.load) begin
      ovf_q <= 1'b0;
    end else if (wrap) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit. Expected out/tc(/ovf) values are
// computed from a behavioural model when stimulus is driven, queued, and
// compared against the DUT one edge later.
module tb_counter_4bit;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;

  counter_4bit_if #(.WIDTH(WIDTH)) bus ();

  counter_4bit #(.WIDTH(WIDTH), .RESET_VAL(32'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    out;
    logic  tc;
    logic  ovf;
  } exp_t;

  exp_t sb_q[$];

  int   n_chk = 0;
  int   n_err = 0;

  int   m_cnt = 0;
  logic m_tc  = 1'b0;
  logic m_ovf = 1'b0;

  int   tc_pulses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare
  // the DUT output just after the edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic ud, input logic ld, input int lv);
    exp_t x;
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.up_dn    = ud;
    bus.load     = ld;
    bus.load_val = lv[WIDTH-1:0];
    if (r) begin
      m_cnt = 0; m_tc = 1'b0; m_ovf = 1'b0;
    end else if (ld) begin
      m_cnt = lv % 16; m_tc = 1'b0; m_ovf = 1'b0;
    end else if (e) begin
      if (ud) begin
        m_tc  = (m_cnt == 15);
        m_cnt = (m_cnt + 1) % 16;
      end else begin
        m_tc  = (m_cnt == 0);
        m_cnt = (m_cnt + 15) % 16;
      end
      if (m_tc) m_ovf = 1'b1;
    end else begin
      m_tc = 1'b0;
    end
    x.tag = tag; x.out = m_cnt; x.tc = m_tc; x.ovf = m_ovf;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      chk({x.tag, "_out"}, 32'(bus.out), 32'(x.out));
      chk({x.tag, "_tc"},  32'(bus.tc),  32'(x.tc));
`ifdef COUNTER_OVERFLOW_STICKY_EN
      chk({x.tag, "_ovf"}, 32'(bus.ovf), 32'(x.ovf));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.up_dn = 1'b1; bus.load = 1'b0; bus.load_val = '0;

    // Reset, then free count for 20 clocks: wraps once, ends at 4.
    repeat (2) step("reset", 1, 1, 1, 0, 0);
    chk("reset_out", 32'(bus.out), 32'd0);
    tc_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step("count", 0, 1, 1, 0, 0);
      if (bus.tc) begin
        tc_pulses++;
        chk("tc_at_zero", 32'(bus.out), 32'd0);
      end
    end
    chk("count20_out", 32'(bus.out), 32'd4);
    chk("count20_tc_pulses", 32'(tc_pulses), 32'd1);

    // Reset mid-count at 9, then restart at 1.
    repeat (5) step("to9", 0, 1, 1, 0, 0);
    chk("at9", 32'(bus.out), 32'd9);
    repeat (2) step("midrst", 1, 1, 1, 0, 0);
    step("restart", 0, 1, 1, 0, 0);
    chk("restart_out", 32'(bus.out), 32'd1);

    // Load 3, hold with en=0, then advance.
    step("load3", 0, 0, 1, 1, 3);
    repeat (5) step("hold", 0, 0, 1, 0, 0);
    chk("hold_out", 32'(bus.out), 32'd3);
    step("resume", 0, 1, 1, 0, 0);
    chk("resume_out", 32'(bus.out), 32'd4);

    // Up wrap from 0xE.
    step("ldE", 0, 1, 1, 1, 14);
    step("upF", 0, 1, 1, 0, 0);
    step("up0", 0, 1, 1, 0, 0);
    chk("upwrap_tc", 32'(bus.tc), 32'd1);
    step("up1", 0, 1, 1, 0, 0);
    chk("up1_out", 32'(bus.out), 32'd1);

    // Down wrap from 0x1, then load beats enable.
    step("ld1", 0, 1, 0, 1, 1);
    step("dn0", 0, 1, 0, 0, 0);
    step("dnF", 0, 1, 0, 0, 0);
    chk("dnwrap_out", 32'(bus.out), 32'hF);
    chk("dnwrap_tc", 32'(bus.tc), 32'd1);
    step("dnE", 0, 1, 0, 0, 0);
    step("ld_wins", 0, 1, 0, 1, 5);
    chk("ld_wins_out", 32'(bus.out), 32'd5);

`ifdef COUNTER_OVERFLOW_STICKY_EN
    step("ovf_ldF", 0, 1, 1, 1, 15);
    step("ovf_wrap", 0, 1, 1, 0, 0);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 10; i++) step("ovf_stay", 0, 1'($urandom_range(0, 1)), 1, 0, 0);
    chk("ovf_stay", 32'(bus.ovf), 32'd1);
    step("ovf_clr", 0, 1, 1, 1, 7);
    chk("ovf_clr", 32'(bus.ovf), 32'd0);
`endif

    // Random mix of controls, including direction flips.
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)));
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
